// File: rtl/mont_domain_conv.sv
// Montgomery domain converter: NCH parallel WIDTH-bit channels, one shift/add-sub step per cycle.
// Converts x -> x*2^WIDTH mod p (to_mont=1) or x -> x*2^-WIDTH mod p (to_mont=0).
module mont_domain_conv #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_sig,
    input  logic                   to_mont,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [WIDTH-1:0]       prime,
    output logic [NCH*WIDTH-1:0]   dout,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  p_q;
    logic              mode_q;
    logic              err_q;

    logic start;
    logic prime_bad;

    assign start     = (state_q == S_IDLE) && in_sig;
    assign prime_bad = ~prime[0] || (prime < WIDTH'(3));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_sig) begin
                    state_d = prime_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        err  = err_q;
    end

    // Modulus, mode and error flag are captured once at acceptance and held until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            p_q    <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (start) begin
            cnt_q  <= '0;
            p_q    <= prime;
            mode_q <= to_mont;
            err_q  <= prime_bad;
        end else if (state_q == S_RUN) begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] din_k;
            logic [WIDTH-1:0] load_val;
            logic [WIDTH:0]   dbl;
            logic [WIDTH:0]   dbl_sub;
            logic [WIDTH-1:0] to_step;
            logic [WIDTH:0]   half_sum;
            logic [WIDTH-1:0] from_step;

            assign din_k    = din[gi*WIDTH +: WIDTH];
            // Only one conditional subtraction on load; inputs >= 2p stay unreduced.
            assign load_val = (din_k >= prime) ? (din_k - prime) : din_k;

            assign dbl      = {x_q, 1'b0};
            assign dbl_sub  = dbl - {1'b0, p_q};
            assign to_step  = (dbl >= {1'b0, p_q}) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];

            // Carry of x + p is kept so the halving never loses the top bit.
            assign half_sum  = {1'b0, x_q} + (x_q[0] ? {1'b0, p_q} : {(WIDTH+1){1'b0}});
            assign from_step = half_sum[WIDTH:1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    x_q <= '0;
                end else if (start) begin
                    x_q <= prime_bad ? '0 : load_val;
                end else if (state_q == S_RUN) begin
                    x_q <= mode_q ? to_step : from_step;
                end
            end

            assign dout[gi*WIDTH +: WIDTH] = x_q;
        end
    endgenerate

endmodule

// File: tb/tb_mont_domain_conv.sv
// Bench for mont_domain_conv: a 32x2 and an 8x3 instance checked against a modular-arithmetic model.
`timescale 1ns/1ps
module tb_mont_domain_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in32 = 1'b0, in8 = 1'b0;
    logic        to_mont_v = 1'b0;
    logic [95:0] din_v = '0;
    logic [31:0] prime_v = '0;

    logic [63:0] dout32;
    logic [23:0] dout8;
    logic        busy32, done32, err32;
    logic        busy8, done8, err8;

    int          sel_v = 0;
    logic [95:0] dout_m;
    logic        busy_m, done_m, err_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mont_domain_conv #(.WIDTH(32), .NCH(2)) u_dut32 (
        .clk(clk), .reset(rst_n), .in_sig(in32), .to_mont(to_mont_v),
        .din(din_v[63:0]), .prime(prime_v),
        .dout(dout32), .busy(busy32), .done(done32), .err(err32)
    );

    mont_domain_conv #(.WIDTH(8), .NCH(3)) u_dut8 (
        .clk(clk), .reset(rst_n), .in_sig(in8), .to_mont(to_mont_v),
        .din(din_v[23:0]), .prime(prime_v[7:0]),
        .dout(dout8), .busy(busy8), .done(done8), .err(err8)
    );

    always_comb begin
        if (sel_v == 0) begin
            dout_m = {32'd0, dout32};
            busy_m = busy32;
            done_m = done32;
            err_m  = err32;
        end else begin
            dout_m = {72'd0, dout8};
            busy_m = busy8;
            done_m = done8;
            err_m  = err8;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic; leaving the domain multiplies by ((p+1)/2)^w, the inverse of 2^w.
    function automatic logic [95:0] model(input int w, input int nch, input bit tm,
                                          input logic [31:0] p, input logic [95:0] d);
        logic [127:0] mask, x, r, inv, pp, res;
        res = '0;
        if (p[0] == 1'b0 || p < 32'd3) return '0;
        pp   = {96'd0, p};
        mask = (128'd1 << w) - 128'd1;
        inv  = 128'd1;
        for (int i = 0; i < w; i++) inv = (inv * ((pp + 128'd1) >> 1)) % pp;
        for (int k = 0; k < nch; k++) begin
            x = ({32'd0, d} >> (k * w)) & mask;
            if (x >= pp) x = x - pp;
            r = tm ? ((x << w) % pp) : ((x * inv) % pp);
            res = res | (r << (k * w));
        end
        return res[95:0];
    endfunction

    task automatic set_start(input int sel, input bit s);
        in32 = s && (sel == 0);
        in8  = s && (sel == 1);
    endtask

    task automatic run_conv(input int sel, input bit tm, input logic [31:0] p, input logic [95:0] d,
                            input int intr_cyc, input int abort_cyc, input string tag,
                            output logic [95:0] got);
        int          w, nch, done_cyc, n_done, busy_bad;
        bit          exp_err, exp_busy;
        logic [95:0] exp_dout;
        logic        err_at_done;
        w        = (sel == 0) ? 32 : 8;
        nch      = (sel == 0) ? 2 : 3;
        exp_err  = (p[0] == 1'b0) || (p < 32'd3);
        exp_dout = model(w, nch, tm, p, d);
        done_cyc = -1; n_done = 0; busy_bad = 0; got = '0; err_at_done = 1'b0;
        sel_v    = sel;
        @(negedge clk);
        to_mont_v = tm; prime_v = p; din_v = d;
        set_start(sel, 1'b1);
        for (int cyc = 1; cyc <= w + 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            set_start(sel, cyc == intr_cyc);
            din_v     = ~d;
            prime_v   = $urandom;
            to_mont_v = ~tm;
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_eq({tag, "_rst_dout"}, {32'd0, dout_m}, 128'd0);
                check_eq({tag, "_rst_flags"}, {125'd0, busy_m, done_m, err_m}, 128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int c = 0; c < w + 4; c++) begin
                    @(negedge clk);
                    if (done_m) n_done++;
                end
                check_eq({tag, "_no_done_after_rst"}, n_done, 0);
                return;
            end
            exp_busy = !exp_err && (cyc <= w);
            if (busy_m !== exp_busy) busy_bad++;
            if (done_m) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    got         = dout_m;
                    err_at_done = err_m;
                end
            end
        end
        set_start(sel, 1'b0);
        check_eq({tag, "_done_cycle"}, done_cyc, exp_err ? 1 : w + 1);
        check_eq({tag, "_done_count"}, n_done, 1);
        check_eq({tag, "_busy_profile"}, busy_bad, 0);
        check_eq({tag, "_dout"}, {32'd0, got}, {32'd0, exp_dout});
        check_eq({tag, "_err"}, err_at_done, exp_err);
        check_eq({tag, "_dout_held"}, {32'd0, dout_m}, {32'd0, exp_dout});
        check_eq({tag, "_err_held"}, err_m, exp_err);
    endtask

    initial begin
        logic [95:0] r, back, d;
        logic [31:0] p, x, y;
        logic [7:0]  p8;

        #1;
        check_eq("reset_dout32", {64'd0, dout32}, 128'd0);
        check_eq("reset_dout8", {104'd0, dout8}, 128'd0);
        check_eq("reset_flags", {122'd0, busy32, done32, err32, busy8, done8, err8}, 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        p = 32'hFFFF_FFFB;
        run_conv(0, 1'b1, p, {32'd0, 32'd2, 32'd1}, 0, 0, "tm_1_2", r);
        check_eq("tm_1_2_lit", {32'd0, r}, {32'd0, 32'd0, 32'd10, 32'd5});
        run_conv(0, 1'b0, p, {32'd0, 32'd10, 32'd5}, 0, 0, "fm_5_10", r);
        check_eq("fm_5_10_lit", {32'd0, r}, {32'd0, 32'd0, 32'd2, 32'd1});

        run_conv(1, 1'b1, 32'd251, {72'd0, 8'd0, 8'd252, 8'd3}, 0, 0, "w8_tm", r);
        check_eq("w8_tm_lit", {32'd0, r}, {104'd0, 8'd0, 8'd5, 8'd15});

        run_conv(0, 1'b0, 32'h10, {32'd0, 32'd7, 32'd9}, 0, 0, "even_p", r);
        run_conv(0, 1'b1, p, {32'd0, 32'd3, 32'd4}, 0, 0, "after_err", r);
        run_conv(1, 1'b1, 32'd1, {72'd0, 24'h123456}, 0, 0, "p_one", r);

        run_conv(0, 1'b1, p, {32'd0, 32'h1234_5678, 32'h0BAD_F00D}, 5, 0, "ignore", r);
        run_conv(1, 1'b0, 32'd239, {72'd0, 8'd17, 8'd200, 8'd238}, 3, 0, "ignore8", r);

        run_conv(0, 1'b1, p, {32'd0, 32'd77, 32'd99}, 0, 10, "abort", r);
        run_conv(0, 1'b1, p, {32'd0, 32'd77, 32'd99}, 0, 0, "post_abort", r);

        for (int i = 0; i < 500; i++) begin
            x = 32'($urandom % {32'd0, p});
            y = 32'($urandom % {32'd0, p});
            d = {32'd0, y, x};
            run_conv(0, 1'b1, p, d, 0, 0, "rt_to", r);
            run_conv(0, 1'b0, p, r, 0, 0, "rt_from", back);
            check_eq("roundtrip", {32'd0, back}, {32'd0, d});
        end

        for (int i = 0; i < 100; i++) begin
            p8 = 8'($urandom_range(3, 255)) | 8'd1;
            d  = '0;
            for (int k = 0; k < 3; k++) d[k*8 +: 8] = 8'($urandom % {24'd0, p8});
            run_conv(1, 1'($urandom), {24'd0, p8}, d, 0, 0, "rand8", r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mont_domain_conv.md
# mont_domain_conv

Parametrised Montgomery domain converter for the ECC datapath. It converts NCH field elements in parallel, each WIDTH bits wide, either into the Montgomery domain (x·2^WIDTH mod p) or back out of it (x·2^−WIDTH mod p), using one shift/conditional-add-subtract step per cycle. It sits between the point I/O registers and the Montgomery multiplier/point-arithmetic core. Compared with the fixed 2×32-bit converter it adds:
- width and channel-count parameters;
- a latched modulus;
- a busy/ignore rule for start;
- an odd-modulus check;
- held outputs.

## Interface
Parameters:
- WIDTH, 32, field element width in bits; also the Montgomery exponent (R = 2^WIDTH); must be ≥ 4
- NCH, 2, number of independent channels (coordinates) converted in parallel

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- in_sig  in  1  start request; sampled only in IDLE
- to_mont  in  1  mode at start: 1 = into Montgomery domain, 0 = out of it
- din  in  NCH*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
- prime  in  WIDTH  modulus p; sampled at start
- dout  out  NCH*WIDTH  packed results, same packing as din
- busy  out  1  high from the cycle after start acceptance until done is asserted
- done  out  1  one-cycle pulse; dout valid
- err  out  1  asserted with done when the modulus is invalid (p even or p < 3); held until next start

## Operation
- **States:**
  - IDLE: on in_sig=1, latch p_r=prime and mode_r=to_mont. Per channel, load x = din_k − p if din_k ≥ p, else din_k. A single subtraction only: inputs ≥ 2p give an unreduced, unspecified result. If p is even or p < 3, go to DONE with err=1. Otherwise go to RUN.
  - RUN: counter runs 0..WIDTH−1, one step per channel per cycle. When counter = WIDTH−1, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- **To-Mont step:** s = {x,1'b0}, WIDTH+1 bits. If s ≥ p_r, x ← s − p_r; else x ← s.
- **From-Mont step:** if x[0]=1, x ← (x + p_r) >> 1; else x ← x >> 1. The sum is computed at WIDTH+1 bits with the carry kept.
- **Range:** all channels share p_r and mode_r. With x < p, every step keeps x < p.
- **dout:** driven from the channel registers. During RUN it shows intermediate values. It holds the final result from DONE until the next start is accepted. On err, dout = 0.
- **Start handling:** in_sig is ignored in RUN and DONE. It is not queued. Changes to din, prime or to_mont after acceptance have no effect.
- **Reset:** reset mid-operation aborts immediately. The block returns to IDLE and no done is produced.

## Timing
- **Reset values:** state=IDLE, counter=0, dout=0, busy=0, done=0, err=0, p_r=0, mode_r=0.
- **Acceptance:** cycle 0 has in_sig=1 in IDLE. At the edge ending cycle 0, the channel registers load and busy rises.
- **RUN:** occupies cycles 1..WIDTH, with one step applied at each edge.
- **Done:** done=1 and busy=0 in cycle WIDTH+1, so latency from start to done is WIDTH+1 cycles.
- **Next start:** the earliest is in_sig in cycle WIDTH+2 (IDLE), giving a throughput of one conversion per WIDTH+2 cycles.
- **Invalid modulus:** done=1 and err=1 in cycle 1. busy never rises.
- **Registered outputs:** done and err come from state registers, with no combinational path from inputs.

## Test plan
- WIDTH=32, NCH=2, p=0xFFFFFFFB, to_mont=1, din={x=1, y=2} -> done in cycle 33; dout = {5, 10}; busy high in cycles 1–32.
- Same p, to_mont=0, din={5, 10} -> dout = {1, 2}. Also run a random x round trip, to_mont then from_mont, and check it returns x; repeat over 1000 random x < p.
- WIDTH=8, NCH=3, p=251, to_mont=1, din={3, 252, 0} -> dout = {15, 5, 0}. 252 is reduced to 1 on load; done in cycle 9.
- p=0x10 (even), to_mont=0 -> done=1 and err=1 in cycle 1, dout=0, busy stays 0. The next valid start clears err.
- Start accepted, then in_sig=1 with new din at cycle 5 -> ignored; the result matches the first operands, with exactly one done pulse.
- reset low at cycle 10 of RUN -> all outputs 0 immediately. After release, no done appears unless a new start is given; a fresh conversion then completes correctly.
